// File: rtl/pc_unit_if.sv
// Fetch-PC request/response bundle: redirect requests in, registered PC and status out.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_4;
  logic             fetch_valid;
  logic             redirect;
  logic             ras_empty;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
    output jr, jr_target, call, ret,
    input  pc, pc_plus_4, fetch_valid, redirect, ras_empty
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
    input  jr, jr_target, call, ret,
    output pc, pc_plus_4, fetch_valid, redirect, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC generator: jr > jump > branch > pc+4, one-entry pending slot across stalls.
// Defining PC_UNIT_RAS_EN builds a circular return-address stack for call/ret.
//
// state   | meaning
// BOOT    | out of reset, pc=RESET_PC, fetch not yet valid, requests ignored
// RUN     | fetching, pc advances or redirects on every unstalled edge
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input logic      clk_i,
  input logic      rst_i,
  pc_unit_if.slave bus
);

  typedef enum logic {ST_BOOT, ST_RUN} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_JUMP, SRC_JR} src_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             fetch_valid_q, fetch_valid_d;
  src_e             pend_src_q, pend_src_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_call_q, pend_call_d;
  logic             pend_ret_q, pend_ret_d;

  src_e             new_src, app_src;
  logic [WIDTH-1:0] new_tgt, app_tgt;
  logic             app_call, app_ret;
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] ras_top;
  logic             ras_avail, ras_push, ras_pop;

  function automatic logic [WIDTH-1:0] align4(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  assign pc_plus_4 = pc_q + WIDTH'(4);

  always_comb begin
    new_src = SRC_NONE;
    new_tgt = bus.branch_target;
    if (bus.jr) begin
      new_src = SRC_JR;
      new_tgt = bus.jr_target;
    end else if (bus.jump) begin
      new_src = SRC_JUMP;
      new_tgt = bus.jump_target;
    end else if (bus.branch_taken) begin
      new_src = SRC_BRANCH;
    end
  end

  // A fresh request on the releasing edge outranks whatever was parked during the stall.
  assign app_src  = (new_src != SRC_NONE) ? new_src  : pend_src_q;
  assign app_tgt  = (new_src != SRC_NONE) ? new_tgt  : pend_tgt_q;
  assign app_call = (new_src != SRC_NONE) ? bus.call : pend_call_q;
  assign app_ret  = (new_src != SRC_NONE) ? bus.ret  : pend_ret_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_d    = 1'b0;
    fetch_valid_d = fetch_valid_q;
    pend_src_d    = pend_src_q;
    pend_tgt_d    = pend_tgt_q;
    pend_call_d   = pend_call_q;
    pend_ret_d    = pend_ret_q;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end
      ST_RUN: begin
        fetch_valid_d = 1'b1;
        if (bus.stall) begin
          if (new_src != SRC_NONE) begin
            pend_src_d  = new_src;
            pend_tgt_d  = new_tgt;
            pend_call_d = bus.call;
            pend_ret_d  = bus.ret;
          end
        end else begin
          pend_src_d = SRC_NONE;
          unique case (app_src)
            SRC_JR: begin
              redirect_d = 1'b1;
              if (app_ret && ras_avail) begin
                pc_d    = align4(ras_top);
                ras_pop = 1'b1;
              end else begin
                pc_d = align4(app_tgt);
              end
            end
            SRC_JUMP: begin
              redirect_d = 1'b1;
              pc_d       = align4(app_tgt);
              ras_push   = app_call;
            end
            SRC_BRANCH: begin
              redirect_d = 1'b1;
              pc_d       = align4(app_tgt);
            end
            default: pc_d = pc_plus_4;
          endcase
        end
      end
      default: begin
        state_d       = ST_BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      redirect_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      pend_src_q    <= SRC_NONE;
      pend_tgt_q    <= '0;
      pend_call_q   <= 1'b0;
      pend_ret_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_q    <= redirect_d;
      fetch_valid_q <= fetch_valid_d;
      pend_src_q    <= pend_src_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_call_q   <= pend_call_d;
      pend_ret_q    <= pend_ret_d;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0]   SP_ONE   = PW'(1);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     RAS_FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_sp_q, ras_top_idx;
  logic [PW:0]      ras_cnt_q;

  // ras_sp_q points at the next write slot; when full it is also the oldest entry.
  assign ras_top_idx = ras_sp_q - SP_ONE;
  assign ras_top     = ras_mem[ras_top_idx];
  assign ras_avail   = (ras_cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (ras_push) ras_mem[ras_sp_q] <= pc_plus_4;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_sp_q <= ras_sp_q + SP_ONE;
      if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + CNT_ONE;
    end else if (ras_pop) begin
      ras_sp_q  <= ras_top_idx;
      ras_cnt_q <= ras_cnt_q - CNT_ONE;
    end
  end

  assign bus.ras_empty = ~ras_avail;
`else
  logic unused_ras;
  assign ras_top       = '0;
  assign ras_avail     = 1'b0;
  assign unused_ras    = ^{ras_push, ras_pop, RAS_DEPTH[0]};
  assign bus.ras_empty = 1'b1;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus_4   = pc_plus_4;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.redirect    = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a queue-based next-PC reference model.
module tb_pc_unit;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int K_NONE = 0, K_BR = 1, K_JMP = 2, K_JR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst8 = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(W)) bus32 ();
  pc_unit_if #(.WIDTH(8)) bus8 ();

  pc_unit #(.WIDTH(W), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus32));
  pc_unit #(.WIDTH(8), .RESET_PC(8'h0), .RAS_DEPTH(2)) dut8 (
    .clk_i(clk), .rst_i(rst8), .bus(bus8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [W-1:0] m_pc;
  bit           m_fv, m_redir, m_boot;
  bit           p_valid;
  int           p_kind;
  logic [W-1:0] p_tgt;
  bit           p_call, p_ret;
  logic [W-1:0] m_ras[$];

  function automatic logic [W-1:0] al(input logic [W-1:0] a);
    return {a[W-1:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_fv = 0; m_redir = 0; m_boot = 1; p_valid = 0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    int k; logic [W-1:0] t; bit c, r;
    k = bus32.jr ? K_JR : bus32.jump ? K_JMP : bus32.branch_taken ? K_BR : K_NONE;
    t = bus32.jr ? bus32.jr_target : bus32.jump ? bus32.jump_target : bus32.branch_target;
    c = bus32.call; r = bus32.ret;
    if (m_boot) begin
      m_boot = 0; m_fv = 1; m_redir = 0;
      return;
    end
    if (bus32.stall) begin
      m_redir = 0;
      if (k != K_NONE) begin
        p_valid = 1; p_kind = k; p_tgt = t; p_call = c; p_ret = r;
      end
      return;
    end
    if (k == K_NONE && p_valid) begin
      k = p_kind; t = p_tgt; c = p_call; r = p_ret;
    end
    p_valid = 0;
    m_redir = (k != K_NONE);
    case (k)
      K_JR: begin
`ifdef PC_UNIT_RAS_EN
        if (r && m_ras.size() > 0) t = m_ras.pop_back();
`endif
        m_pc = al(t);
      end
      K_JMP: begin
`ifdef PC_UNIT_RAS_EN
        if (c) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        m_pc = al(t);
      end
      K_BR:    m_pc = al(t);
      default: m_pc = m_pc + 32'd4;
    endcase
  endtask

  task automatic check_outputs();
    logic [W-1:0] e4;
    bit e_empty;
    e4 = m_pc + 32'd4;
`ifdef PC_UNIT_RAS_EN
    e_empty = (m_ras.size() == 0);
`else
    e_empty = 1;
`endif
    check_val("pc", bus32.pc, m_pc);
    check_val("pc_plus_4", bus32.pc_plus_4, e4);
    check_val("fetch_valid", bus32.fetch_valid, m_fv);
    check_val("redirect", bus32.redirect, m_redir);
    check_val("ras_empty", bus32.ras_empty, e_empty);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus32.stall = 0; bus32.branch_taken = 0; bus32.jump = 0; bus32.jr = 0;
    bus32.call = 0; bus32.ret = 0;
    bus32.branch_target = '0; bus32.jump_target = '0; bus32.jr_target = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_val("rst_pc", bus32.pc, 0);
    check_val("rst_fetch_valid", bus32.fetch_valid, 0);
    check_val("rst_redirect", bus32.redirect, 0);
    check_val("rst_ras_empty", bus32.ras_empty, 1);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic go_to(input logic [W-1:0] a);
    idle(); bus32.jump = 1; bus32.jump_target = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus8.stall = 0; bus8.branch_taken = 0; bus8.jump = 0; bus8.jr = 0;
    bus8.call = 0; bus8.ret = 0;
    bus8.branch_target = '0; bus8.jump_target = '0; bus8.jr_target = '0;
    model_reset();
    @(posedge clk); #1;

    // 8-bit instance: sequential wrap 0xFC -> 0x00
    rst8 = 0;
    @(posedge clk); #1;
    check_val("w8_boot_pc", bus8.pc, 8'h00);
    check_val("w8_boot_fv", bus8.fetch_valid, 1);
    bus8.jump = 1; bus8.jump_target = 8'hFA;
    @(posedge clk); #1;
    check_val("w8_jump_pc", bus8.pc, 8'hF8);
    bus8.jump = 0;
    @(posedge clk); #1;
    check_val("w8_pc_fc", bus8.pc, 8'hFC);
    check_val("w8_plus4_wrap", bus8.pc_plus_4, 8'h00);
    @(posedge clk); #1;
    check_val("w8_wrap_pc", bus8.pc, 8'h00);
    check_val("w8_wrap_redirect", bus8.redirect, 0);

    // reset release, sequential fetch
    do_reset();
    check_outputs();
    tick(); check_val("seq_pc0", bus32.pc, 32'h0); check_val("seq_fv", bus32.fetch_valid, 1);
    tick(); check_val("seq_pc4", bus32.pc, 32'h4);
    tick(); check_val("seq_pc8", bus32.pc, 32'h8); check_val("seq_redirect", bus32.redirect, 0);

    // priority jr > jump > branch, target alignment
    go_to(32'h100);
    bus32.jr = 1; bus32.jr_target = 32'h203;
    bus32.jump = 1; bus32.jump_target = 32'h400;
    bus32.branch_taken = 1; bus32.branch_target = 32'h600;
    tick();
    check_val("prio_pc", bus32.pc, 32'h200);
    check_val("prio_redirect", bus32.redirect, 1);
    idle(); tick();
    check_val("prio_redirect_clr", bus32.redirect, 0);

    // branch captured during a 3-cycle stall, applied on release
    go_to(32'h40);
    bus32.stall = 1; bus32.branch_taken = 1; bus32.branch_target = 32'h80;
    tick();
    bus32.branch_taken = 0;
    tick(); tick();
    check_val("stall_hold_pc", bus32.pc, 32'h40);
    check_val("stall_redirect", bus32.redirect, 0);
    bus32.stall = 0;
    tick();
    check_val("pend_apply_pc", bus32.pc, 32'h80);
    check_val("pend_apply_redirect", bus32.redirect, 1);

    // new request on release outranks pending
    bus32.stall = 1; bus32.branch_taken = 1; bus32.branch_target = 32'h300;
    tick();
    idle(); bus32.jump = 1; bus32.jump_target = 32'h500;
    tick();
    check_val("new_over_pend", bus32.pc, 32'h500);
    idle(); tick();
    check_val("pend_cleared", bus32.pc, 32'h504);

    // reset discards a pending entry
    bus32.stall = 1; bus32.jump = 1; bus32.jump_target = 32'h700;
    tick();
    idle();
    do_reset();
    tick(); tick();
    check_val("rst_discard_pc", bus32.pc, 32'h4);

    // sequential wrap at full width
    go_to(32'hFFFF_FFFC);
    tick();
    check_val("w32_wrap_pc", bus32.pc, 32'h0);

`ifdef PC_UNIT_RAS_EN
    do_reset(); tick();
    for (int i = 1; i <= 5; i++) begin
      go_to(32'(i * 16));
      bus32.jump = 1; bus32.call = 1; bus32.jump_target = 32'h800;
      tick();
    end
    begin
      logic [W-1:0] exp_ret [5];
      exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34;
      exp_ret[3] = 32'h24; exp_ret[4] = 32'h998;
      for (int i = 0; i < 5; i++) begin
        idle(); bus32.jr = 1; bus32.ret = 1; bus32.jr_target = 32'h999;
        tick();
        check_val("ras_ret_pc", bus32.pc, exp_ret[i]);
        if (i == 3) check_val("ras_empty_after4", bus32.ras_empty, 1);
      end
    end
    idle();
`endif

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
        check_outputs();
      end
      bus32.stall         = ($urandom_range(0, 3) == 0);
      bus32.jr            = ($urandom_range(0, 7) == 0);
      bus32.jump          = ($urandom_range(0, 5) == 0);
      bus32.branch_taken  = ($urandom_range(0, 4) == 0);
      bus32.call          = 1'($urandom_range(0, 1));
      bus32.ret           = 1'($urandom_range(0, 1));
      bus32.jr_target     = $urandom();
      bus32.jump_target   = 32'($urandom_range(0, 16'hFFFF));
      bus32.branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : $urandom();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 WIDTH, 32, PC and target width in bits; legal range 8..64.
REQ-002 RESET_PC, 0, PC value loaded by reset; bits [1:0] SHALL be 0.
REQ-003 RAS_DEPTH, 4, return-address stack entries; power of two, >=2; used only with PC_UNIT_RAS_EN.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  1 = hold PC this cycle.
REQ-007 branch_taken  input  1  conditional branch resolved taken.
REQ-008 branch_target  input  WIDTH  branch destination.
REQ-009 jump  input  1  unconditional jump (j/jal).
REQ-010 jump_target  input  WIDTH  jump destination.
REQ-011 jr  input  1  register-indirect jump.
REQ-012 jr_target  input  WIDTH  register-indirect destination.
REQ-013 call  input  1  qualifies jump as a linking call (jal).
REQ-014 ret  input  1  qualifies jr as a return.
REQ-015 pc  output  WIDTH  current fetch address, registered.
REQ-016 pc_plus_4  output  WIDTH  pc+4 modulo 2^WIDTH, combinational from pc.
REQ-017 fetch_valid  output  1  pc holds a valid fetch address, registered.
REQ-018 redirect  output  1  pc was loaded from a non-sequential source on the last edge, registered.
REQ-019 ras_empty  output  1  return-address stack holds no entries.

Function
REQ-020 FSM SHALL have two states: BOOT (entered on reset) and RUN; BOOT SHALL advance to RUN at the first edge after reset deasserts, regardless of stall.
REQ-021 In BOOT: pc=RESET_PC, fetch_valid=0, redirect=0; all redirect inputs SHALL be ignored.
REQ-022 In RUN: fetch_valid=1.
REQ-023 Next-PC priority SHALL be jr > jump > branch_taken > pc_plus_4; only the winning source SHALL have any effect.
REQ-024 Any loaded target SHALL have bits [1:0] forced to 0.
REQ-025 stall=1 at an edge: pc SHALL hold and redirect SHALL be 0 next cycle; the winning request (if any) SHALL be captured in a one-entry pending register with its call/ret qualifiers, replacing any older pending entry.
REQ-026 First edge with stall=0: a new request present that cycle SHALL win over the pending entry; otherwise the pending entry SHALL be applied; pending SHALL then clear.
REQ-027 redirect SHALL be 1 for exactly one cycle after each edge where pc was loaded from jr, jump, or branch (new or pending).
REQ-028 Sequential pc SHALL wrap from 2^WIDTH-4 to 0 without a flag.

Reset
REQ-029 reset=1 SHALL immediately (no clock) set pc=RESET_PC, fetch_valid=0, redirect=0, pending empty, RAS count 0, ras_empty=1, state BOOT.
REQ-030 Reset asserted mid-stall or with a pending entry SHALL discard that entry; no push/pop occurs.

Configuration
REQ-031 Macro PC_UNIT_RAS_EN defined: a RAS_DEPTH-entry circular return-address stack SHALL be built.
REQ-032 With RAS: when jump with call is applied, pc_plus_4 SHALL be pushed; on full, the oldest entry is overwritten and count saturates at RAS_DEPTH.
REQ-033 With RAS: when jr with ret is applied and stack non-empty, the target SHALL be the top entry (not jr_target) and it SHALL be popped; when empty, jr_target is used, no pop.
REQ-034 Push/pop SHALL occur only at the edge the request is applied (not on capture into pending).
REQ-035 Macro undefined: no stack logic; call and ret ignored; ras_empty tied to 1.

Verification
REQ-036 Reset release, stall=0, no requests -> pc 0x0 (fetch_valid=0), then 0x0, 0x4, 0x8 with fetch_valid=1, redirect=0.
REQ-037 pc=0x100, jr=1 jr_target=0x203, jump=1 jump_target=0x400, branch_taken=1 same cycle -> pc=0x200, redirect=1 for one cycle.
REQ-038 stall=1 for 3 cycles at pc=0x40, branch_taken=1 target 0x80 in cycle 1 only -> pc holds 0x40, then 0x80 on first unstalled edge, redirect=1.
REQ-039 WIDTH=8, pc=0xFC -> next pc 0x00.
REQ-040 PC_UNIT_RAS_EN, RAS_DEPTH=4: five calls from pc 0x10,0x20,0x30,0x40,0x50 then five ret jr with jr_target=0x999 -> targets 0x54,0x44,0x34,0x24, then 0x998; ras_empty=1 after fourth return.
